// File: rtl/cache_pkg.sv
// Shared cache constants, resolver FSM state type and response record.
package cache_pkg;

   localparam int WAYS         = 8;
   localparam int WAY_NO_SIZE  = 3;
   localparam int SETS         = 64;
   localparam int SET_IDX_SIZE = 6;
   localparam int TAG_SIZE     = 22;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RESOLVE = 2'd1,
      RESPOND = 2'd2
   } resolver_state_e;

   typedef struct packed {
      logic                   hit;
      logic [WAY_NO_SIZE-1:0] hit_way;
      logic [WAY_NO_SIZE-1:0] victim_way;
      logic                   err;
   } resolve_resp_t;

   function automatic logic [WAY_NO_SIZE:0] count_ones(input logic [WAYS-1:0] vec);
      logic [WAY_NO_SIZE:0] cnt;
      cnt = '0;
      for (int i = 0; i < WAYS; i++) begin
         cnt = cnt + {{WAY_NO_SIZE{1'b0}}, vec[i]};
      end
      return cnt;
   endfunction

endpackage

// File: rtl/way_hit_resolver_plru_tree.sv
// Combinational tree-PLRU: victim walk over the current bits and the
// updated bits after touching access_way.
module plru_tree
   import cache_pkg::*;
(
   input  logic [WAYS-2:0]        bits_in,
   input  logic [WAY_NO_SIZE-1:0] access_way,
   output logic [WAY_NO_SIZE-1:0] victim_way,
   output logic [WAYS-2:0]        bits_out
);

   logic [WAY_NO_SIZE-1:0] node_v_s;
   logic [WAY_NO_SIZE-1:0] node_u_s;

   // Victim walk: follow each node bit from the root (0 = lower half).
   always_comb begin
      node_v_s   = '0;
      victim_way = '0;
      for (int lvl = 0; lvl < WAY_NO_SIZE; lvl++) begin
         victim_way[WAY_NO_SIZE-1-lvl] = bits_in[node_v_s];
         node_v_s = WAY_NO_SIZE'({node_v_s, 1'b1} + {{WAY_NO_SIZE{1'b0}}, bits_in[node_v_s]});
      end
   end

   // Kept separate from the walk so access_way (which may be the victim) forms no loop.
   always_comb begin
      node_u_s = '0;
      bits_out = bits_in;
      for (int lvl = 0; lvl < WAY_NO_SIZE; lvl++) begin
         bits_out[node_u_s] = ~access_way[WAY_NO_SIZE-1-lvl];
         node_u_s = WAY_NO_SIZE'({node_u_s, 1'b1} + {{WAY_NO_SIZE{1'b0}}, access_way[WAY_NO_SIZE-1-lvl]});
      end
   end

endmodule

// File: rtl/way_hit_resolver.sv
// Resolves hit/miss, hit way, victim way and error for one cache lookup,
// maintaining per-set tree-PLRU state behind a valid/ready handshake.
module way_hit_resolver
   import cache_pkg::*;
(
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          req_valid,
   output logic                          req_ready,
   input  logic [SET_IDX_SIZE-1:0]       set_index,
   input  logic [WAYS-1:0]               comp_result,
   input  logic [WAYS*WAY_NO_SIZE-1:0]   way_no_in,
   input  logic [WAYS-1:0]               valid_bits,
   output logic                          resp_valid,
   input  logic                          resp_ready,
   output logic                          hit,
   output logic [WAY_NO_SIZE-1:0]        hit_way,
   output logic [WAY_NO_SIZE-1:0]        victim_way,
   output logic                          err
);

   resolver_state_e                state_r, state_next_s;
   logic                           req_ready_r, resp_valid_r, accept_s;
   resolve_resp_t                  resp_r, resp_next_s;
   logic [SET_IDX_SIZE-1:0]        set_r;
   logic [WAYS-1:0]                comp_r, valid_r, match_s;
   logic [WAYS*WAY_NO_SIZE-1:0]    way_no_r;
   logic [WAYS-2:0]                plru_r [SETS];
   logic [WAYS-2:0]                plru_cur_s, plru_new_s;
   logic [WAY_NO_SIZE-1:0]         hit_way_s, invalid_way_s, plru_victim_s, access_way_s, chosen_no_s;
   logic                           any_invalid_s;

   assign accept_s   = (state_r == IDLE) && req_valid && req_ready_r;
   assign plru_cur_s = plru_r[set_r];

   plru_tree u_plru (
      .bits_in    (plru_cur_s),
      .access_way (access_way_s),
      .victim_way (plru_victim_s),
      .bits_out   (plru_new_s)
   );

   // Next-state logic.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         IDLE:    state_next_s = accept_s ? RESOLVE : IDLE;
         RESOLVE: state_next_s = RESPOND;
         RESPOND: state_next_s = resp_ready ? IDLE : RESPOND;
         default: state_next_s = IDLE;
      endcase
   end

   // Hit/victim resolution; way 0 is identified only through its match bit.
   always_comb begin
      match_s       = comp_r & valid_r;
      any_invalid_s = ~(&valid_r);
      hit_way_s     = '0;
      invalid_way_s = '0;
      for (int w = WAYS-1; w >= 0; w--) begin
         hit_way_s     = match_s[w]  ? WAY_NO_SIZE'(w) : hit_way_s;
         invalid_way_s = !valid_r[w] ? WAY_NO_SIZE'(w) : invalid_way_s;
      end
      chosen_no_s = way_no_r[hit_way_s*WAY_NO_SIZE +: WAY_NO_SIZE];
      resp_next_s = '0;
      resp_next_s.hit = |match_s;
      if (|match_s) begin
         resp_next_s.hit_way = hit_way_s;
         resp_next_s.err     = (count_ones(match_s) > {{WAY_NO_SIZE{1'b0}}, 1'b1}) ||
                               (chosen_no_s != hit_way_s);
         access_way_s        = hit_way_s;
      end else begin
         resp_next_s.victim_way = any_invalid_s ? invalid_way_s : plru_victim_s;
         access_way_s           = resp_next_s.victim_way;
      end
   end

   // FSM, handshake flags, captured request and registered response.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= IDLE;
         req_ready_r  <= 1'b0;
         resp_valid_r <= 1'b0;
         resp_r       <= '0;
         set_r        <= '0;
         comp_r       <= '0;
         valid_r      <= '0;
         way_no_r     <= '0;
      end else begin
         state_r      <= state_next_s;
         req_ready_r  <= (state_next_s == IDLE);
         resp_valid_r <= (state_next_s == RESPOND);
         if (state_r == RESOLVE) begin
            resp_r <= resp_next_s;
         end
         if (accept_s) begin
            set_r    <= set_index;
            comp_r   <= comp_result;
            valid_r  <= valid_bits;
            way_no_r <= way_no_in;
         end
      end
   end

   // PLRU storage; a write coinciding with reset is dropped.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int s = 0; s < SETS; s++) begin
            plru_r[s] <= '0;
         end
      end else if (state_r == RESOLVE) begin
         plru_r[set_r] <= plru_new_s;
      end
   end

   assign req_ready  = req_ready_r;
   assign resp_valid = resp_valid_r;
   assign hit        = resp_r.hit;
   assign hit_way    = resp_r.hit_way;
   assign victim_way = resp_r.victim_way;
   assign err        = resp_r.err;

endmodule
